// File: rtl/alu_arb_pkg.sv
// Shared field widths, ALU funct codes and the operand bundle used by the ALU share arbiter.
package alu_arb_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SHAMT_W  = 5;
  localparam int unsigned CTRL_W   = 6;
  localparam int unsigned IMM_W    = 16;

  localparam logic [CTRL_W-1:0] FUNCT_SLL = 6'b000000;
  localparam logic [CTRL_W-1:0] FUNCT_SRL = 6'b000010;
  localparam logic [CTRL_W-1:0] FUNCT_SRA = 6'b000011;
  localparam logic [CTRL_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [CTRL_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [CTRL_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [CTRL_W-1:0] FUNCT_OR  = 6'b100101;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [DATA_W-1:0]   rs;
    logic [DATA_W-1:0]   rt;
    logic [SHAMT_W-1:0]  shamt;
    logic [CTRL_W-1:0]   ctrl;
    logic [IMM_W-1:0]    imm;
  } alu_op_t;

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: first set request bit after rr_ptr, wrapping at N_REQ-1.
module alu_rr_pick #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  winner,
  output logic             any
);

  int unsigned idx;

  always_comb begin
    idx    = 0;
    winner = '0;
    any    = 1'b0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = ID_W'(idx);
      end
    end
    grant = any ? (N_REQ'(1) << winner) : '0;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between N_REQ requesters with a registered valid/ready response.
// Optional per-requester grant counters are built when ALU_ARB_STATS_EN is defined.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*6-1:0]       req_opcode,
  input  logic [N_REQ*32-1:0]      req_rs_content,
  input  logic [N_REQ*32-1:0]      req_rt_content,
  input  logic [N_REQ*5-1:0]       req_shamt,
  input  logic [N_REQ*6-1:0]       req_alu_control,
  input  logic [N_REQ*16-1:0]      req_immediate,
  output logic [5:0]               alu_opcode,
  output logic [31:0]              alu_rs_content,
  output logic [31:0]              alu_rt_content,
  output logic [4:0]               alu_shamt,
  output logic [5:0]               alu_control,
  output logic [15:0]              alu_immediate,
  input  logic [31:0]              alu_result,
  input  logic                     alu_sig_branch,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [31:0]              rsp_result,
  output logic                     rsp_branch
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [N_REQ*CNT_W-1:0]   grant_cnt
`endif
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StFull = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  winner;
  logic [N_REQ-1:0] grant;
  logic             any;
  logic             slot;
  logic             grant_en;
  alu_op_t          op_sel;

  alu_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .grant  (grant),
    .winner (winner),
    .any    (any)
  );

  // An issue slot opens when the output register is empty or is being drained this cycle.
  assign slot      = !rst && ((state_q == StIdle) || rsp_ready);
  assign grant_en  = slot && any;
  assign req_ready = grant_en ? grant : '0;
  assign rsp_valid = (state_q == StFull);

  always_comb begin
    op_sel = '0;
    if (grant_en) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (winner == ID_W'(i)) begin
          op_sel.opcode = req_opcode[i*OPCODE_W +: OPCODE_W];
          op_sel.rs     = req_rs_content[i*DATA_W +: DATA_W];
          op_sel.rt     = req_rt_content[i*DATA_W +: DATA_W];
          op_sel.shamt  = req_shamt[i*SHAMT_W +: SHAMT_W];
          op_sel.ctrl   = req_alu_control[i*CTRL_W +: CTRL_W];
          op_sel.imm    = req_immediate[i*IMM_W +: IMM_W];
        end
      end
    end
  end

  assign alu_opcode     = op_sel.opcode;
  assign alu_rs_content = op_sel.rs;
  assign alu_rt_content = op_sel.rt;
  assign alu_shamt      = op_sel.shamt;
  assign alu_control    = op_sel.ctrl;
  assign alu_immediate  = op_sel.imm;

  always_comb begin
    state_d = state_q;
    if (grant_en) begin
      state_d = StFull;
    end else if ((state_q == StFull) && rsp_ready) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= ID_W'(N_REQ - 1);
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_branch <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        rr_ptr_q   <= winner;
        rsp_id     <= winner;
        rsp_result <= alu_result;
        rsp_branch <= alu_sig_branch;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (grant_en && (winner == ID_W'(g)) && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
    assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized self-checking bench for alu_share_arbiter against a transaction-level reference model.
module tb_alu_share_arbiter;

  localparam int N  = 2;
  localparam int IW = 1;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*6-1:0]  req_opcode;
  logic [N*32-1:0] req_rs_content;
  logic [N*32-1:0] req_rt_content;
  logic [N*5-1:0]  req_shamt;
  logic [N*6-1:0]  req_alu_control;
  logic [N*16-1:0] req_immediate;
  logic [5:0]      alu_opcode;
  logic [31:0]     alu_rs_content;
  logic [31:0]     alu_rt_content;
  logic [4:0]      alu_shamt;
  logic [5:0]      alu_control;
  logic [15:0]     alu_immediate;
  logic [31:0]     alu_result;
  logic            alu_sig_branch;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [31:0]     rsp_result;
  logic            rsp_branch;
`ifdef ALU_ARB_STATS_EN
  logic [N*CW-1:0] grant_cnt;
`endif

  logic [5:0]  op_a [N];
  logic [31:0] rs_a [N];
  logic [31:0] rt_a [N];
  logic [4:0]  sh_a [N];
  logic [5:0]  ct_a [N];
  logic [15:0] im_a [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_opcode[g*6 +: 6]       = op_a[g];
    assign req_rs_content[g*32 +: 32] = rs_a[g];
    assign req_rt_content[g*32 +: 32] = rt_a[g];
    assign req_shamt[g*5 +: 5]        = sh_a[g];
    assign req_alu_control[g*6 +: 6]  = ct_a[g];
    assign req_immediate[g*16 +: 16]  = im_a[g];
  end

  alu_share_arbiter #(
    .N_REQ (N),
    .ID_W  (IW),
    .CNT_W (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_opcode      (req_opcode),
    .req_rs_content  (req_rs_content),
    .req_rt_content  (req_rt_content),
    .req_shamt       (req_shamt),
    .req_alu_control (req_alu_control),
    .req_immediate   (req_immediate),
    .alu_opcode      (alu_opcode),
    .alu_rs_content  (alu_rs_content),
    .alu_rt_content  (alu_rt_content),
    .alu_shamt       (alu_shamt),
    .alu_control     (alu_control),
    .alu_immediate   (alu_immediate),
    .alu_result      (alu_result),
    .alu_sig_branch  (alu_sig_branch),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_id          (rsp_id),
    .rsp_result      (rsp_result),
    .rsp_branch      (rsp_branch)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt       (grant_cnt)
`endif
  );

  // Behavioural ALU: {sig_branch, result}.
  function automatic logic [32:0] alu_fn(input logic [5:0] c, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] s);
    logic [31:0] r;
    case (c)
      6'b000000: r = b << s;
      6'b000010: r = b >> s;
      6'b000011: r = 32'($signed(b) >>> s);
      6'b100000: r = a + b;
      6'b100010: r = a - b;
      6'b100100: r = a & b;
      6'b100101: r = a | b;
      default:   r = a ^ b;
    endcase
    return {a == b, r};
  endfunction

  assign {alu_sig_branch, alu_result} = alu_fn(alu_control, alu_rs_content, alu_rt_content,
                                               alu_shamt);

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a one-entry response slot plus the last granted requester.
  bit          m_full;
  int          m_id;
  logic [31:0] m_res;
  bit          m_br;
  int          m_ptr;
  int          m_cnt [N];
  int          last_grant;

  task automatic model_reset();
    m_full = 0;
    m_id   = 0;
    m_res  = '0;
    m_br   = 0;
    m_ptr  = N - 1;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic cycle();
    int          w;
    bit          open;
    logic [32:0] f;
    logic [96:0] exp_alu;
    @(negedge clk);
    open = !rst && (!m_full || rsp_ready);
    w = -1;
    if (open) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (w < 0 && req_valid[c]) w = c;
      end
    end
    check("req_ready", 128'(req_ready), (w < 0) ? 128'd0 : (128'd1 << w));
    exp_alu = (w < 0) ? 97'd0 : {op_a[w], rs_a[w], rt_a[w], sh_a[w], ct_a[w], im_a[w]};
    check("alu_ports", 128'({alu_opcode, alu_rs_content, alu_rt_content, alu_shamt, alu_control,
                             alu_immediate}), 128'(exp_alu));
    check("rsp_valid", 128'(rsp_valid), 128'(m_full));
    if (m_full) begin
      check("rsp_id", 128'(rsp_id), 128'(m_id));
      check("rsp_result", 128'(rsp_result), 128'(m_res));
      check("rsp_branch", 128'(rsp_branch), 128'(m_br));
    end
`ifdef ALU_ARB_STATS_EN
    for (int i = 0; i < N; i++) check("grant_cnt", 128'(grant_cnt[i*CW +: CW]), 128'(m_cnt[i]));
`endif
    last_grant = w;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else if (w >= 0) begin
      f      = alu_fn(ct_a[w], rs_a[w], rt_a[w], sh_a[w]);
      m_full = 1;
      m_id   = w;
      m_res  = f[31:0];
      m_br   = f[32];
      m_ptr  = w;
      if (m_cnt[w] < (2 ** CW) - 1) m_cnt[w]++;
    end else if (rsp_ready) begin
      m_full = 0;
    end
  endtask

  function automatic logic [5:0] pick_ctrl(input int k);
    case (k)
      0: return 6'b000000;
      1: return 6'b000010;
      2: return 6'b000011;
      3: return 6'b100000;
      4: return 6'b100010;
      5: return 6'b100100;
      6: return 6'b100101;
      default: return 6'b111111;
    endcase
  endfunction

  task automatic new_op(input int i);
    op_a[i] = 6'($urandom_range(0, 63));
    rs_a[i] = $urandom;
    rt_a[i] = ($urandom_range(0, 7) == 0) ? rs_a[i] : $urandom;
    sh_a[i] = 5'($urandom_range(0, 31));
    ct_a[i] = pick_ctrl($urandom_range(0, 7));
    im_a[i] = 16'($urandom_range(0, 65535));
  endtask

  // Pending requests keep operands until granted, but may be withdrawn.
  task automatic rand_stim();
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && last_grant != i) begin
        if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
      end else begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        new_op(i);
      end
    end
    rsp_ready = ($urandom_range(0, 3) != 0);
    rst       = ($urandom_range(0, 63) == 0);
  endtask

  int          prev;
  logic [31:0] held;

  initial begin
    for (int i = 0; i < N; i++) new_op(i);
    last_grant = -1;
    model_reset();
    rst       = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    check("rst_result", 128'(rsp_result), 128'd0);
    check("rst_id", 128'(rsp_id), 128'd0);

    // Single SRA on requester 0.
    rst       = 1'b0;
    req_valid = 2'b01;
    new_op(0);
    ct_a[0] = 6'b000011;
    rt_a[0] = 32'd12;
    sh_a[0] = 5'd1;
    cycle();
    check("sra_grant", 128'(last_grant), 128'd0);
    check("sra_result", 128'(rsp_result), 128'd6);
    check("sra_id", 128'(rsp_id), 128'd0);
    req_valid = 2'b00;
    cycle();

    // Contention: grants must alternate.
    req_valid = 2'b11;
    new_op(0);
    new_op(1);
    prev = 0;
    for (int n = 0; n < 6; n++) begin
      cycle();
      check("rr_alt", 128'(last_grant), 128'(1 - prev));
      prev = last_grant;
      new_op(last_grant);
    end

    // Backpressure holds the response and blocks grants.
    rsp_ready = 1'b0;
    held      = rsp_result;
    for (int n = 0; n < 3; n++) cycle();
    check("bp_hold", 128'(rsp_result), 128'(held));
    rsp_ready = 1'b1;
    cycle();
    check("bp_next", 128'(last_grant), 128'(1 - prev));

    // ADD on requester 1 after draining.
    req_valid = 2'b00;
    cycle();
    cycle();
    new_op(1);
    rs_a[1] = 32'd5;
    rt_a[1] = 32'd7;
    ct_a[1] = 6'b100000;
    req_valid = 2'b10;
    cycle();
    check("add_result", 128'(rsp_result), 128'd12);
    check("add_id", 128'(rsp_id), 128'd1);
    req_valid = 2'b00;
    cycle();
    cycle();
    check("idle_alu", 128'({alu_rs_content, alu_rt_content, alu_control}), 128'd0);

    // Mid-operation reset, then three grants to requester 0.
    req_valid = 2'b01;
    new_op(0);
    cycle();
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    rst       = 1'b1;
    cycle();
    check("midrst_valid", 128'(rsp_valid), 128'd0);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 2'b01;
    for (int n = 0; n < 3; n++) begin
      new_op(0);
      cycle();
    end
    req_valid = 2'b00;
    cycle();
`ifdef ALU_ARB_STATS_EN
    check("cnt_three", 128'(grant_cnt[CW-1:0]), 128'd3);
`endif

    for (int n = 0; n < 400; n++) begin
      rand_stim();
      cycle();
    end
    rst = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
